// File: rtl/phase_scan_ctrl.sv
// phase_scan_ctrl: scans downsampler phases, measures BER per phase and locks onto the best one
module phase_scan_ctrl #(
    parameter int OV_SAMP   = 4,
    parameter int NB_PHASE  = 2,
    parameter int NB_WINDOW = 16,
    parameter int NB_ERR    = 16,
    parameter int SETTLE    = 16
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_valid,
    input  logic                 i_err,
    input  logic [NB_WINDOW-1:0] i_window,
    output logic [NB_PHASE-1:0]  o_phase,
    output logic                 o_ber_rst,
    output logic                 o_busy,
    output logic                 o_locked,
    output logic [NB_ERR-1:0]    o_best_err
);
    localparam int NB_SET = $clog2(SETTLE + 1);

    typedef enum logic [2:0] {ST_IDLE, ST_SETTLE, ST_MEASURE, ST_NEXT, ST_LOCK} state_t;

    state_t               state;
    logic [NB_WINDOW-1:0] window;
    logic [NB_WINDOW-1:0] sym_cnt;
    logic [NB_WINDOW-1:0] sym_nxt;
    logic [NB_WINDOW-1:0] win_cap;
    logic [NB_ERR-1:0]    err_cnt;
    logic [NB_ERR-1:0]    err_nxt;
    logic [NB_ERR-1:0]    best_err;
    logic [NB_PHASE-1:0]  cur_phase;
    logic [NB_PHASE-1:0]  best_phase;
    logic [NB_SET-1:0]    settle_cnt;
    logic                 better;

    // next counter values, saturating error count, strict best compare, zero-window fixup
    always_comb begin
        sym_nxt = sym_cnt + 1'b1;
        err_nxt = (i_err && err_cnt != '1) ? err_cnt + 1'b1 : err_cnt;
        better  = err_cnt < best_err;
        win_cap = (i_window == '0) ? NB_WINDOW'(1) : i_window;
    end

    // scan FSM with registered outputs; abort on enable low beats every other transition
    always_ff @(posedge i_clock) begin
        o_ber_rst <= 1'b0;
        if (i_reset) begin
            state      <= ST_IDLE;
            window     <= '0;
            sym_cnt    <= '0;
            err_cnt    <= '0;
            best_err   <= '0;
            cur_phase  <= '0;
            best_phase <= '0;
            settle_cnt <= '0;
            o_phase    <= '0;
            o_busy     <= 1'b0;
            o_locked   <= 1'b0;
            o_best_err <= '0;
        end else if (state != ST_IDLE && !i_enable) begin
            state    <= ST_IDLE;
            o_phase  <= '0;
            o_busy   <= 1'b0;
            o_locked <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (i_enable) begin
                    state      <= ST_SETTLE;
                    cur_phase  <= '0;
                    best_err   <= '1;
                    best_phase <= '0;
                    settle_cnt <= '0;
                    window     <= win_cap;
                    o_ber_rst  <= 1'b1;
                    o_busy     <= 1'b1;
                end
                ST_SETTLE: if (i_valid) begin
                    if (settle_cnt == NB_SET'(SETTLE - 1)) begin
                        state   <= ST_MEASURE;
                        err_cnt <= '0;
                        sym_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                ST_MEASURE: if (i_valid) begin
                    sym_cnt <= sym_nxt;
                    err_cnt <= err_nxt;
                    if (sym_nxt == window) state <= ST_NEXT;
                end
                ST_NEXT: begin
                    o_ber_rst <= 1'b1;
                    if (better) begin
                        best_err   <= err_cnt;
                        best_phase <= cur_phase;
                    end
                    if (cur_phase == NB_PHASE'(OV_SAMP - 1)) begin
                        state      <= ST_LOCK;
                        o_phase    <= better ? cur_phase : best_phase;
                        o_best_err <= better ? err_cnt : best_err;
                        o_locked   <= 1'b1;
                        o_busy     <= 1'b0;
                    end else begin
                        state      <= ST_SETTLE;
                        cur_phase  <= cur_phase + 1'b1;
                        o_phase    <= cur_phase + 1'b1;
                        settle_cnt <= '0;
                        window     <= win_cap;
                    end
                end
                default: state <= state;
            endcase
        end
    end
endmodule
